// File: rtl/apb_master_arbiter_if.sv
// apb_master_arbiter_if: requester command/response and APB signals of the arbiter
interface apb_master_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] req_valid, req_write, req_ready, rsp_valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [DATA_WIDTH-1:0] rsp_rdata, PWDATA, PRDATA;
  logic rsp_err, PSEL, PENABLE, PWRITE, PNSE, PREADY, PSLVERR;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [2:0] PPROT;
  modport master (
    input req_valid, req_write, req_addr, req_wdata, PREADY, PSLVERR, PRDATA,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA, PPROT, PNSE
  );
  modport slave (
    output req_valid, req_write, req_addr, req_wdata, PREADY, PSLVERR, PRDATA,
    input req_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA, PPROT, PNSE
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin requester arbiter sequencing single APB transfers with a PREADY watchdog
module apb_master_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 16
) (
  input logic PCLK,
  input logic PRESET,
  apb_master_arbiter_if.master bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state, nxt;
  logic [IW-1:0] rr_ptr, cur, g, idx;
  logic [TW-1:0] wait_cnt;
  logic hit, done;
  // round-robin search starting at rr_ptr; the first valid requester found wins
  always_comb begin
    g = '0;
    hit = 1'b0;
    idx = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!hit && bus.req_valid[idx]) begin
        g = idx;
        hit = 1'b1;
      end
      idx = (idx == IW'(NUM_REQ - 1)) ? '0 : idx + IW'(1);
    end
  end
  assign done = (state == ACCESS) && (bus.PREADY || wait_cnt == TW'(TIMEOUT - 1));
  assign bus.req_ready = (state == IDLE && hit) ? NUM_REQ'(1) << g : '0;
  assign bus.PSEL = state != IDLE;
  assign bus.PENABLE = state == ACCESS;
  assign bus.PPROT = 3'b000;
  assign bus.PNSE = 1'b0;
  // state register
  always_ff @(posedge PCLK) begin
    if (PRESET) state <= IDLE;
    else state <= nxt;
  end
  // next state: accept in IDLE, one SETUP cycle, stay in ACCESS until PREADY or watchdog
  always_comb begin
    nxt = state;
    nxt = state == IDLE ? (hit ? SETUP : IDLE) : state == SETUP ? ACCESS : (done ? IDLE : ACCESS);
  end
  // command latch, wait counter and registered response
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      rr_ptr <= '0;
      cur <= '0;
      wait_cnt <= '0;
      bus.PWRITE <= 1'b0;
      bus.PADDR <= '0;
      bus.PWDATA <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_rdata <= '0;
      bus.rsp_err <= 1'b0;
    end else begin
      bus.rsp_valid <= '0;
      if (state == IDLE && hit) begin
        cur <= g;
        rr_ptr <= (g == IW'(NUM_REQ - 1)) ? '0 : g + IW'(1);
        wait_cnt <= '0;
        bus.PWRITE <= bus.req_write[g];
        bus.PADDR <= bus.req_addr[int'(g)*ADDR_WIDTH +: ADDR_WIDTH];
        bus.PWDATA <= bus.req_wdata[int'(g)*DATA_WIDTH +: DATA_WIDTH];
      end
      if (state == ACCESS) wait_cnt <= wait_cnt + TW'(1);
      if (done) begin
        bus.rsp_valid <= NUM_REQ'(1) << cur;
        bus.rsp_rdata <= bus.PREADY ? (bus.PWRITE ? '0 : bus.PRDATA) : '0;
        bus.rsp_err <= bus.PREADY ? bus.PSLVERR : 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: random requesters and slave checked against a transaction-level model
module tb_apb_master_arbiter;
  localparam int AW = 32;
  localparam int DW = 8;
  localparam int N = 4;
  localparam int TO = 16;
  logic PCLK = 1'b0;
  logic PRESET = 1'b1;
  always #5 PCLK = ~PCLK;
  apb_master_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(N)) bus ();
  apb_master_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(N), .TIMEOUT(TO)) dut (
    .PCLK(PCLK),
    .PRESET(PRESET),
    .bus(bus)
  );
  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int mask = 0, p = 0, dmode = 0, perr = 0;
  int rr = 0, g_cyc = 0, rsp_cyc = 0, acnt = 0;
  int t_idx = 0, t_dly = 0;
  bit busy = 1'b0;
  logic t_w = 1'b0, t_err = 1'b0, e_err = 1'b0;
  logic [AW-1:0] t_a = '0;
  logic [DW-1:0] t_d = '0, e_rd = '0;
  logic [N-1:0] v = '0, w = '0;
  logic [AW-1:0] a [N];
  logic [DW-1:0] d [N];
  logic [DW-1:0] mem [16];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask

  function automatic int pick_dly();
    int s;
    s = int'($urandom_range(5));
    if (dmode == 0) return 0;
    if (dmode == 1) return int'($urandom_range(3));
    if (dmode == 2) return 1000;
    if (dmode == 3) return s < 3 ? s : TO - 5 + s;
    return 5;
  endfunction

  task automatic step(input bit rst_now);
    logic acc, rdy, in_xfer;
    int gi;
    logic [N-1:0] oh;
    @(posedge PCLK);
    #1;
    PRESET = rst_now;
    for (int i = 0; i < N; i++) begin
      if (!v[i] && mask[i] && int'($urandom_range(99)) < p) begin
        v[i] = 1'b1;
        w[i] = 1'($urandom);
        a[i] = $urandom;
        d[i] = DW'($urandom);
      end
      bus.req_valid[i] = v[i];
      bus.req_write[i] = w[i];
      bus.req_addr[i*AW +: AW] = a[i];
      bus.req_wdata[i*DW +: DW] = d[i];
    end
    acc = bus.PSEL && bus.PENABLE;
    rdy = acc ? (acnt >= t_dly) : 1'($urandom);
    bus.PREADY = rdy;
    bus.PSLVERR = (acc && rdy) ? t_err : 1'($urandom);
    bus.PRDATA = (acc && rdy && !bus.PWRITE) ? mem[bus.PADDR[3:0]] : DW'($urandom);
    @(negedge PCLK);
    cyc++;
    if (rst_now) begin
      busy = 1'b0;
      rr = 0;
      acnt = 0;
      return;
    end
    in_xfer = busy && cyc > g_cyc && cyc < rsp_cyc;
    check("psel", bus.PSEL, in_xfer);
    check("penable", bus.PENABLE, in_xfer && cyc > g_cyc + 1);
    if (in_xfer) begin
      check("paddr", bus.PADDR, t_a);
      check("pwrite", bus.PWRITE, t_w);
      check("pwdata", bus.PWDATA, t_d);
    end
    oh = (busy && cyc == rsp_cyc) ? N'(1) << t_idx : N'(0);
    check("rsp_valid", bus.rsp_valid, oh);
    if (oh != 0) begin
      check("rsp_rdata", bus.rsp_rdata, e_rd);
      check("rsp_err", bus.rsp_err, e_err);
      busy = 1'b0;
    end
    if (acc && rdy && bus.PWRITE && !bus.PSLVERR) mem[bus.PADDR[3:0]] = bus.PWDATA;
    if (acc) acnt++;
    gi = -1;
    if (!busy)
      for (int k = 0; k < N; k++)
        if (gi < 0 && v[(rr + k) % N]) gi = (rr + k) % N;
    check("req_ready", bus.req_ready, gi < 0 ? N'(0) : N'(1) << gi);
    if (gi >= 0) begin
      t_idx = gi;
      t_w = w[gi];
      t_a = a[gi];
      t_d = d[gi];
      t_dly = pick_dly();
      t_err = int'($urandom_range(99)) < perr;
      g_cyc = cyc;
      rsp_cyc = cyc + 2 + (t_dly + 1 < TO ? t_dly + 1 : TO);
      e_err = t_dly >= TO || t_err;
      e_rd = (t_dly >= TO || t_w) ? '0 : mem[t_a[3:0]];
      v[gi] = 1'b0;
      rr = (gi + 1) % N;
      acnt = 0;
      busy = 1'b1;
    end
  endtask

  task automatic phase(input int m, input int prob, input int dm, input int pe, input int n);
    mask = m;
    p = prob;
    dmode = dm;
    perr = pe;
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  initial begin
    bit found;
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.PREADY = 1'b0;
    bus.PSLVERR = 1'b0;
    bus.PRDATA = '0;
    for (int i = 0; i < 16; i++) mem[i] = DW'($urandom);
    for (int i = 0; i < N; i++) begin
      a[i] = '0;
      d[i] = '0;
    end
    step(1'b1);
    step(1'b1);
    check("rst_psel", bus.PSEL, 0);
    check("rst_penable", bus.PENABLE, 0);
    check("rst_pwrite", bus.PWRITE, 0);
    check("rst_paddr", bus.PADDR, 0);
    check("rst_pwdata", bus.PWDATA, 0);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("pprot", bus.PPROT, 0);
    check("pnse", bus.PNSE, 0);
    phase(4'hF, 100, 0, 0, 30);
    phase(4'h2, 50, 1, 0, 40);
    phase(4'hF, 40, 1, 30, 200);
    phase(4'hF, 60, 2, 0, 80);
    phase(4'hF, 50, 3, 20, 200);
    phase(0, 0, 0, 0, 40);
    phase(4'h9, 100, 1, 0, 60);
    mask = 4'hF;
    p = 100;
    dmode = 4;
    perr = 0;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      step(1'b0);
      found = busy && t_idx == 2 && cyc + 1 >= g_cyc + 2 && cyc + 1 < rsp_cyc;
    end
    check("reset_reach_access2", found, 1);
    step(1'b1);
    step(1'b0);
    check("post_rst_rdata", bus.rsp_rdata, 0);
    check("post_rst_err", bus.rsp_err, 0);
    check("post_rst_grant0", bus.req_ready, 1);
    phase(4'hF, 70, 1, 20, 40);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
